// File: rtl/uart_tx_bridge_if.sv
// Ctrl-to-bridge and bridge-to-UART-tx signal bundle.
// master is the bridge side; slave is the ctrl/tx-module side.
interface uart_tx_bridge_if #(
    parameter int unsigned HEADER_SIZE  = 32,
    parameter int unsigned MESSAGE_SIZE = 512
);
    logic [HEADER_SIZE-1:0]  header_in;
    logic [MESSAGE_SIZE-1:0] message_in;
    logic                    ctrl_valid_in;
    logic                    bdge_ready_out;
    logic [7:0]              ll_byte_out;
    logic                    ll_valid_out;
    logic                    ll_ready_in;
    logic                    bdge_done_out;

    modport master (
        input  header_in,
        input  message_in,
        input  ctrl_valid_in,
        input  ll_ready_in,
        output bdge_ready_out,
        output ll_byte_out,
        output ll_valid_out,
        output bdge_done_out
    );

    modport slave (
        output header_in,
        output message_in,
        output ctrl_valid_in,
        output ll_ready_in,
        input  bdge_ready_out,
        input  ll_byte_out,
        input  ll_valid_out,
        input  bdge_done_out
    );
endinterface

// File: rtl/uart_tx_bridge.sv
// Serialises a captured header+message pair into a byte stream for a UART tx,
// header first, each word sent least-significant byte first.
module uart_tx_bridge #(
    parameter int unsigned MESSAGE_SIZE = 512,
    parameter int unsigned HEADER_SIZE  = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    uart_tx_bridge_if.master  bus
);
    localparam int unsigned HDR_BYTES = HEADER_SIZE / 8;
    localparam int unsigned MSG_BYTES = MESSAGE_SIZE / 8;
    localparam int unsigned HIDX_W    = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int unsigned MIDX_W    = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [HIDX_W-1:0] HDR_LAST = HIDX_W'(HDR_BYTES - 1);
    localparam logic [MIDX_W-1:0] MSG_LAST = MIDX_W'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SEND_HEADER  = 2'd1,
        SEND_MESSAGE = 2'd2
    } state_e;

    state_e                     state_q,   state_d;
    logic [HDR_BYTES-1:0][7:0]  header_q,  header_d;
    logic [MSG_BYTES-1:0][7:0]  message_q, message_d;
    logic [HIDX_W-1:0]          hdr_idx_q, hdr_idx_d;
    logic [MIDX_W-1:0]          msg_idx_q, msg_idx_d;
    logic [7:0]                 byte_q,    byte_d;
    logic                       valid_q,   valid_d;
    logic                       ready_q,   ready_d;
    logic                       done_q,    done_d;

    logic              accept_c;
    logic              xfer_c;
    logic [HIDX_W-1:0] hdr_nxt_c;
    logic [MIDX_W-1:0] msg_nxt_c;

    assign accept_c  = bus.ctrl_valid_in && ready_q;
    assign xfer_c    = valid_q && bus.ll_ready_in;
    assign hdr_nxt_c = hdr_idx_q + HIDX_W'(1);
    assign msg_nxt_c = msg_idx_q + MIDX_W'(1);

    assign bus.bdge_ready_out = ready_q;
    assign bus.ll_byte_out    = byte_q;
    assign bus.ll_valid_out   = valid_q;
    assign bus.bdge_done_out  = done_q;

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            header_q  <= '0;
            message_q <= '0;
            hdr_idx_q <= '0;
            msg_idx_q <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            header_q  <= header_d;
            message_q <= message_d;
            hdr_idx_q <= hdr_idx_d;
            msg_idx_q <= msg_idx_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         if (accept_c)                state_d = SEND_HEADER;
            SEND_HEADER:  if (xfer_c && hdr_idx_q == HDR_LAST) state_d = SEND_MESSAGE;
            SEND_MESSAGE: if (xfer_c && msg_idx_q == MSG_LAST) state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the next byte is loaded on the same edge
    // that retires the current one so the stream has no bubbles.
    always_comb begin
        header_d  = header_q;
        message_d = message_q;
        hdr_idx_d = hdr_idx_q;
        msg_idx_d = msg_idx_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ready_d   = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    header_d  = bus.header_in;
                    message_d = bus.message_in;
                    hdr_idx_d = '0;
                    msg_idx_d = '0;
                    byte_d    = bus.header_in[7:0];
                    valid_d   = 1'b1;
                end
            end
            SEND_HEADER: begin
                if (xfer_c) begin
                    if (hdr_idx_q == HDR_LAST) begin
                        hdr_idx_d = '0;
                        byte_d    = message_q[0];
                    end else begin
                        hdr_idx_d = hdr_nxt_c;
                        byte_d    = header_q[hdr_nxt_c];
                    end
                end
            end
            SEND_MESSAGE: begin
                if (xfer_c) begin
                    if (msg_idx_q == MSG_LAST) begin
                        msg_idx_d = '0;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        msg_idx_d = msg_nxt_c;
                        byte_d    = message_q[msg_nxt_c];
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/uart_tx_bridge.md
UART_TX_BRIDGE -- requirements
Module: uart_tx_bridge

Interface
REQ-001 SHALL have parameter MESSAGE_SIZE, default 512, message width in bits; multiple of 8, >= 8.
REQ-002 SHALL have parameter HEADER_SIZE, default 32, header width in bits; multiple of 8, >= 8.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n_in  input  1  asynchronous active-low reset.
REQ-006 header_in  input  HEADER_SIZE  header word from ctrl, sampled on ctrl acceptance.
REQ-007 message_in  input  MESSAGE_SIZE  message word from ctrl, sampled on ctrl acceptance.
REQ-008 ctrl_valid_in  input  1  ctrl presents header_in/message_in for transmission.
REQ-009 bdge_ready_out  output  1  bridge can accept a new header+message.
REQ-010 ll_byte_out  output  8  byte to the UART tx module.
REQ-011 ll_valid_out  output  1  ll_byte_out holds a valid byte.
REQ-012 ll_ready_in  input  1  tx module accepts ll_byte_out this cycle.
REQ-013 bdge_done_out  output  1  single-cycle pulse after the last byte of a frame is accepted.

Function
REQ-014 Ctrl handshake: acceptance occurs on an edge where ctrl_valid_in && bdge_ready_out; header_in and message_in SHALL be captured into internal registers at that edge.
REQ-015 bdge_ready_out SHALL be registered and high only in IDLE; it SHALL NOT depend combinationally on ctrl_valid_in or ll_ready_in.
REQ-016 States SHALL be IDLE, SEND_HEADER, SEND_MESSAGE.
REQ-017 IDLE -> SEND_HEADER on acceptance; bdge_ready_out low and ll_valid_out high with header byte 0 from the next cycle (1-cycle latency).
REQ-018 Byte order SHALL be header first, then message; within each word bits [7:0] first, ascending in 8-bit steps.
REQ-019 Ll transfer occurs on an edge where ll_valid_out && ll_ready_in; only then SHALL the byte index advance and ll_byte_out update.
REQ-020 While ll_valid_out is high and ll_ready_in is low, ll_byte_out and ll_valid_out SHALL hold unchanged; ll_valid_out SHALL NOT depend on ll_ready_in.
REQ-021 SEND_HEADER -> SEND_MESSAGE on transfer of header byte HEADER_SIZE/8-1; message byte 0 SHALL be presented the next cycle with ll_valid_out still high (no bubble).
REQ-022 SEND_MESSAGE -> IDLE on transfer of message byte MESSAGE_SIZE/8-1; next cycle ll_valid_out = 0, bdge_ready_out = 1, bdge_done_out = 1 for exactly one cycle.
REQ-023 A frame SHALL be exactly HEADER_SIZE/8 + MESSAGE_SIZE/8 transfers; indices SHALL be $clog2-sized and reset to 0 on return to IDLE, no wrap mid-frame.
REQ-024 Changes on header_in, message_in or ctrl_valid_in outside IDLE SHALL have no effect on the frame in progress.
REQ-025 A new acceptance SHALL be possible on the cycle bdge_ready_out returns high (minimum one IDLE cycle between frames).
REQ-026 ll_ready_in high while ll_valid_out low SHALL be ignored.

Reset
REQ-027 rst_n_in low SHALL immediately force state IDLE, indices 0, ll_valid_out 0, ll_byte_out 0, bdge_done_out 0, bdge_ready_out 0, captured registers 0.
REQ-028 bdge_ready_out SHALL rise on the first clk_in edge after rst_n_in deasserts.
REQ-029 Reset mid-frame SHALL abort the frame; no further bytes and no bdge_done_out pulse for it.

Verification (HEADER_SIZE=16, MESSAGE_SIZE=32)
REQ-030 header 16'hA1B2, message 32'h11223344, ll_ready_in held 1 -> ll_byte_out B2,A1,44,33,22,11 on 6 consecutive cycles, then one bdge_done_out pulse.
REQ-031 Same frame, ll_ready_in toggled 1/0 pseudo-randomly -> same 6-byte sequence, byte stable while stalled, no duplicates or drops.
REQ-032 header_in/message_in changed to 16'hFFFF/32'h0 one cycle after acceptance -> transmitted bytes remain B2,A1,44,33,22,11.
REQ-033 ctrl_valid_in held high with two frames queued back-to-back -> second frame accepted on the cycle bdge_ready_out rises; 12 bytes total, two done pulses.
REQ-034 rst_n_in pulsed low after 3rd byte transferred -> ll_valid_out 0 asynchronously, no done pulse, bdge_ready_out 1 one edge after release; next frame starts from header byte 0.
